// File: rtl/conv_pkg.sv
// Shared types and helpers for the ROM read arbiter: FSM state encoding and
// the bit-width helper used to size address and id fields.
package conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Number of bits needed to represent value; never less than one.
  function automatic int clogb2(input int value);
    int n;
    n = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      n = n + 1;
    end
    if (n == 0) begin
      n = 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping, returned both one-hot and as an encoded index.
module rr_arbiter
  import conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clogb2(NUM_REQ - 1)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  // Scan from the farthest candidate down so the one closest to ptr wins.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IW{1'b0}};
    grant_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      grant_vld = grant_vld | req[(int'(ptr) + k) % NUM_REQ];
      grant_idx = req[(int'(ptr) + k) % NUM_REQ] ? IW'((int'(ptr) + k) % NUM_REQ) : grant_idx;
    end
    grant[grant_idx] = grant_vld;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output ROM between NUM_REQ burst requesters, granting
// round-robin and returning each word tagged with its owner id.
module rom_read_arbiter
  import conv_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int NUM_REQ   = 4,
  parameter int LEN_W     = 8,
  parameter int AW        = clogb2(RAM_DEPTH - 1),
  parameter int IW        = clogb2(NUM_REQ - 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rom_en,
  output logic [AW-1:0]            rom_addr,
  input  logic [RAM_WIDTH-1:0]     rom_dout,
  output logic                     rd_valid,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic [IW-1:0]            rd_id,
  output logic                     rd_last
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(RAM_DEPTH - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      id_q, id_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               rd_valid_q, rd_last_q;
  logic [IW-1:0]      rd_id_q;

  logic [NUM_REQ-1:0] grant_s;
  logic [IW-1:0]      grant_idx_s;
  logic               grant_vld_s;
  logic [AW-1:0]      addr_inc_s;
  logic [IW-1:0]      ptr_nxt_s;
  logic               cnt_zero_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // Explicit compare keeps the wrap correct for non-power-of-two depths.
  assign addr_inc_s = (addr_q == ADDR_LAST) ? {AW{1'b0}} : addr_q + {{(AW-1){1'b0}}, 1'b1};
  assign ptr_nxt_s  = (grant_idx_s == ID_LAST) ? {IW{1'b0}} : grant_idx_s + {{(IW-1){1'b0}}, 1'b1};
  assign cnt_zero_s = (cnt_q == {LEN_W{1'b0}});

  // Next-state logic; the address is not advanced on the final word so
  // rom_addr holds the last issued address while idle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_s) begin
          state_d = BURST;
          addr_d  = req_addr[grant_idx_s * AW +: AW];
          cnt_d   = req_len[grant_idx_s * LEN_W +: LEN_W];
          id_d    = grant_idx_s;
          ptr_d   = ptr_nxt_s;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (cnt_zero_s) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_inc_s;
          cnt_d  = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= {AW{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      id_q    <= {IW{1'b0}};
      ptr_q   <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // Return pipe tracks the ROM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= {IW{1'b0}};
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == BURST);
      rd_id_q    <= id_q;
      rd_last_q  <= (state_q == BURST) && cnt_zero_s;
    end
  end

  assign req_ready = (state_q == IDLE) ? (grant_s & {NUM_REQ{rst_n}}) : {NUM_REQ{1'b0}};
  assign rom_en    = (state_q == BURST);
  assign rom_addr  = addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rom_dout;
  assign rd_id     = rd_id_q;
  assign rd_last   = rd_last_q;

endmodule
